// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the core load/store port. Accepts one request at a
// time, holds it for WAIT_CYCLES wait states, commits the RV32I load or store
// on the edge that enters the response state, then returns the result over a
// valid/ready response handshake with unlimited backpressure.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   req_valid   request present
//   req_ready   responder can accept a request (registered)
//   req_we      1 = store, 0 = load
//   req_addr    byte address, word index = req_addr[31:2]
//   req_wdata   store data, byte/half from the low bits
//   req_funct3  RV32I size/sign code
//   rsp_valid   response present (registered)
//   rsp_ready   requester accepts the response
//   rsp_rdata   extended load result, 0 for stores and errors (registered)
//   rsp_err     misaligned, out of range or illegal funct3 (registered)
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned WAIT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // State and registered outputs
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic [31:0]   r_rdata;
    logic          r_err;

    // Latched request
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [2:0]    r_funct3;

    logic [31:0]   r_mem [DEPTH_WORDS];

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_req_ready_nxt;
    logic          w_rsp_valid_nxt;
    logic [31:0]   w_rdata_nxt;
    logic          w_err_nxt;
    logic          w_commit;

    logic          w_accept;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [2:0]    w_funct3;
    logic [AW-1:0] w_idx;
    logic          w_in_range;
    logic          w_illegal;
    logic          w_misalign;
    logic          w_err;
    logic [31:0]   w_mem_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load_data;
    logic [3:0]    w_bmask;
    logic [31:0]   w_store_data;
    logic [31:0]   w_store_word;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    assign w_accept = (r_state == S_IDLE) && req_valid && r_req_ready;

    // With zero wait states the commit edge is the accept edge, so the live
    // inputs are decoded in IDLE and the latched copy everywhere else.
    assign w_we     = (r_state == S_IDLE) ? req_we     : r_we;
    assign w_addr   = (r_state == S_IDLE) ? req_addr   : r_addr;
    assign w_wdata  = (r_state == S_IDLE) ? req_wdata  : r_wdata;
    assign w_funct3 = (r_state == S_IDLE) ? req_funct3 : r_funct3;

    assign w_idx      = w_addr[AW+1:2];
    assign w_in_range = (w_addr[31:2] < DEPTH_LIM);
    assign w_mem_word = w_in_range ? r_mem[w_idx] : 32'h0;

    // Error decode
    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        case (w_funct3)
            3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
            3'b100, 3'b101:         w_illegal = w_we;
            default:                w_illegal = 1'b1;
        endcase
        case (w_funct3[1:0])
            2'b01:   w_misalign = w_addr[0];
            2'b10:   w_misalign = |w_addr[1:0];
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_err = w_illegal || w_misalign || !w_in_range;

    // Load lane select and extension
    assign w_byte = w_mem_word[{w_addr[1:0], 3'b000} +: 8];
    assign w_half = w_addr[1] ? w_mem_word[31:16] : w_mem_word[15:0];

    always_comb begin
        w_load_data = 32'h0;
        case (w_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = w_mem_word;
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_data = 32'h0;
        endcase
    end

    // Store merge: replicate data across lanes, then keep unaddressed bytes
    always_comb begin
        w_bmask      = 4'b0000;
        w_store_data = 32'h0;
        case (w_funct3[1:0])
            2'b00: begin
                w_bmask      = 4'b0001 << w_addr[1:0];
                w_store_data = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_bmask      = w_addr[1] ? 4'b1100 : 4'b0011;
                w_store_data = {2{w_wdata[15:0]}};
            end
            2'b10: begin
                w_bmask      = 4'b1111;
                w_store_data = w_wdata;
            end
            default: begin
                w_bmask      = 4'b0000;
                w_store_data = 32'h0;
            end
        endcase
        w_store_word = w_mem_word;
        for (int i = 0; i < 4; i++) begin
            if (w_bmask[i]) begin
                w_store_word[8*i +: 8] = w_store_data[8*i +: 8];
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rdata_nxt     = r_rdata;
        w_err_nxt       = r_err;
        w_commit        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_req_ready_nxt = 1'b0;
                    if (WAIT_CYCLES == 0) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CW'(WAIT_INIT);
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_req_ready_nxt = 1'b1;
                    w_rsp_valid_nxt = 1'b0;
                    w_rdata_nxt     = 32'h0;
                    w_err_nxt       = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_req_ready_nxt = 1'b1;
                w_rsp_valid_nxt = 1'b0;
                w_rdata_nxt     = 32'h0;
                w_err_nxt       = 1'b0;
            end
        endcase
        if (w_commit) begin
            w_rsp_valid_nxt = 1'b1;
            w_err_nxt       = w_err;
            w_rdata_nxt     = (w_err || w_we) ? 32'h0 : w_load_data;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rdata     <= w_rdata_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Request capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we     <= 1'b0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_funct3 <= 3'b000;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
        end
    end

    // Storage is not reset; a write is blocked while reset is held low
    always_ff @(posedge clk) begin
        if (w_commit && w_we && !w_err && reset) begin
            r_mem[w_idx] <= w_store_word;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;

    // Unit A: default two wait states
    logic        valid_a, ready_a, rsp_valid_a, rsp_ready_a, err_a;
    logic [31:0] rdata_a;
    // Unit B: zero wait states
    logic        valid_b, ready_b, rsp_valid_b, rsp_ready_b, err_b;
    logic [31:0] rdata_b;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (valid_a),
        .req_ready  (ready_a),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid_a),
        .rsp_ready  (rsp_ready_a),
        .rsp_rdata  (rdata_a),
        .rsp_err    (err_a)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (valid_b),
        .req_ready  (ready_b),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid_b),
        .rsp_ready  (rsp_ready_b),
        .rsp_rdata  (rdata_b),
        .rsp_err    (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction; inputs are scrambled after accept to confirm latching
    task automatic do_req(input bit sel, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          input logic [31:0] exp_rdata, input bit exp_err,
                          input string tag);
        int lat;
        int exp_lat;
        exp_lat = sel ? 1 : 3;
        @(negedge clk);
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a    = 1'b0;
        valid_b    = 1'b0;
        req_we     = ~we;
        req_addr   = 32'hFFFF_FFFC;
        req_wdata  = 32'h0BAD_0BAD;
        req_funct3 = 3'b111;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(sel ? rsp_valid_b : rsp_valid_a) && lat < 20);
        check32({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check32({tag, ".rdata"}, sel ? rdata_b : rdata_a, exp_rdata);
        check32({tag, ".err"}, {31'h0, sel ? err_b : err_a}, {31'h0, exp_err});
        if (sel) rsp_ready_b = 1'b1; else rsp_ready_a = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_a = 1'b0;
        rsp_ready_b = 1'b0;
    endtask

    initial begin
        int lat;
        reset       = 1'b0;
        valid_a     = 1'b0;
        valid_b     = 1'b0;
        rsp_ready_a = 1'b0;
        rsp_ready_b = 1'b0;
        req_we      = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        req_funct3  = 3'b000;

        // Reset state
        repeat (3) @(negedge clk);
        check32("rst.req_ready", {31'h0, ready_a}, 32'h1);
        check32("rst.rsp_valid", {31'h0, rsp_valid_a}, 32'h0);
        check32("rst.rdata", rdata_a, 32'h0);
        check32("rst.err", {31'h0, err_a}, 32'h0);
        check32("rst.b_ready", {31'h0, ready_b}, 32'h1);
        reset = 1'b1;

        // Word store and load-back
        do_req(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0, "sw10");
        do_req(0, 0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0, "lw10");

        // Sub-word loads
        do_req(0, 0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 0, "lb13");
        do_req(0, 0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 0, "lbu13");
        do_req(0, 0, 32'h12, 32'h0, 3'b001, 32'hFFFFDEAD, 0, "lh12");
        do_req(0, 0, 32'h10, 32'h0, 3'b101, 32'h0000BEEF, 0, "lhu10");

        // Sub-word stores
        do_req(0, 1, 32'h11, 32'hFFFFFF55, 3'b000, 32'h0, 0, "sb11");
        do_req(0, 0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 0, "lw_sb");
        do_req(0, 1, 32'h12, 32'hABCD1234, 3'b001, 32'h0, 0, "sh12");
        do_req(0, 0, 32'h10, 32'h0, 3'b010, 32'h123455EF, 0, "lw_sh");

        // Error cases leave memory untouched
        do_req(0, 0, 32'h12, 32'h0, 3'b010, 32'h0, 1, "lw_mis");
        do_req(0, 1, 32'h11, 32'hFFFFFFFF, 3'b001, 32'h0, 1, "sh_mis");
        do_req(0, 0, 32'h10, 32'h0, 3'b011, 32'h0, 1, "f3_011");
        do_req(0, 1, 32'h10, 32'hFFFFFFFF, 3'b100, 32'h0, 1, "st_f3_100");
        do_req(0, 0, 32'h400, 32'h0, 3'b010, 32'h0, 1, "lw_oor");
        do_req(0, 0, 32'h10, 32'h0, 3'b010, 32'h123455EF, 0, "lw_after_err");

        // Backpressure: response held five cycles
        @(negedge clk);
        req_we     = 1'b0;
        req_addr   = 32'h10;
        req_funct3 = 3'b010;
        valid_a    = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid_a && lat < 20);
        check32("bp.lat", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check32("bp.valid", {31'h0, rsp_valid_a}, 32'h1);
            check32("bp.rdata", rdata_a, 32'h123455EF);
            check32("bp.req_ready", {31'h0, ready_a}, 32'h0);
        end
        rsp_ready_a = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_a = 1'b0;
        @(negedge clk);
        check32("bp.req_ready_after", {31'h0, ready_a}, 32'h1);
        check32("bp.valid_after", {31'h0, rsp_valid_a}, 32'h0);
        check32("bp.rdata_after", rdata_a, 32'h0);

        // Zero wait states
        do_req(1, 1, 32'h40, 32'h87654321, 3'b010, 32'h0, 0, "b.sw40");
        do_req(1, 0, 32'h42, 32'h0, 3'b001, 32'hFFFF8765, 0, "b.lh42");
        do_req(1, 0, 32'h40, 32'h0, 3'b100, 32'h00000021, 0, "b.lbu40");

        // Reset during WAIT drops the store
        do_req(0, 1, 32'h20, 32'h11112222, 3'b010, 32'h0, 0, "sw20_prior");
        @(negedge clk);
        req_we     = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = 32'hCAFEF00D;
        req_funct3 = 3'b010;
        valid_a    = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check32("rstwait.req_ready", {31'h0, ready_a}, 32'h1);
        check32("rstwait.rsp_valid", {31'h0, rsp_valid_a}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        do_req(0, 0, 32'h20, 32'h0, 3'b010, 32'h11112222, 0, "lw20_after_rst");
        do_req(0, 0, 32'h10, 32'h0, 3'b010, 32'h123455EF, 0, "lw10_persist");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory side of the load/store interface driven by the processor datapath.
- Accepts one request at a time over a valid/ready handshake and holds it for a configurable number of wait states.
- Performs RV32I byte, halfword and word loads and stores (little-endian, loads zero- or sign-extended), then returns a response over a second valid/ready handshake.
- Used to verify the multi-cycle and pipelined cores against non-zero memory latency.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words of storage; word index = req_addr[31:2].
WAIT_CYCLES, 2, wait states between request accept and response (0 allowed).

Ports:
clk  input  1  clock, all state changes on rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data; byte/half taken from the low bits
req_funct3  input  3  RV32I funct3 size/sign code
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts the response
rsp_rdata  output  32  load result, already extended; 0 for stores and errors
rsp_err  output  1  request was misaligned, out of range or had an illegal funct3

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, wait counter = 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Any latched request is discarded. An uncommitted store never writes.
  - Memory array is not reset; its contents persist across reset.
- States:
  - IDLE: req_ready = 1. A request is accepted on a rising edge where req_valid & req_ready. On accept, latch we/addr/wdata/funct3.
    - WAIT_CYCLES > 0: go to WAIT with counter = WAIT_CYCLES-1.
    - WAIT_CYCLES = 0: go to RESP.
  - WAIT: req_ready = 0. Counter decrements each cycle. When the counter is 0, go to RESP on the next edge.
  - RESP: req_ready = 0, rsp_valid = 1. rsp_rdata and rsp_err stay stable until the edge where rsp_ready = 1, then go to IDLE and drop rsp_valid. Unlimited backpressure.
- Latency:
  - rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
  - With zero backpressure, back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Commit: the store write and the load read both occur on the edge entering RESP. A load issued after a completed store sees the new data.
- Loads, selected by funct3, byte lane from addr[1:0]:
  - 000 lb: sign-extend byte.
  - 001 lh: sign-extend half at addr[1].
  - 010 lw: full word.
  - 100 lbu: zero-extend byte.
  - 101 lhu: zero-extend half.
  - 011, 110, 111: error.
- Stores:
  - 000 sb: write req_wdata[7:0] to the addressed byte lane.
  - 001 sh: write req_wdata[15:0] to the addressed half.
  - 010 sw: write the full word.
  - Other codes: error.
  - Unaddressed bytes are unchanged.
- Errors (rsp_err = 1, rsp_rdata = 0, no memory write, response timing unchanged):
  - Half access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - Word index >= DEPTH_WORDS.
  - Illegal funct3.
- Inputs are ignored while req_ready = 0. They need not be held after accept.
- When rsp_valid = 0, rsp_rdata and rsp_err read 0.
- Reset asserted during WAIT: the store is dropped and memory is unchanged. Reset asserted during RESP: the store has already committed and stays written.

Test Plan:
- Reset, then sw 0xDEADBEEF @0x10 followed by lw @0x10 -> for each response, rsp_valid rises 3 cycles after accept (WAIT_CYCLES=2); the lw returns rdata=0xDEADBEEF with err=0.
- After the above: lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x12 -> 0xFFFFDEAD; lhu @0x10 -> 0x0000BEEF.
- sb 0x55 @0x11, then lw @0x10 -> 0xDEAD55EF. sh 0x1234 @0x12, then lw @0x10 -> 0x123455EF.
- lw @0x12, sh @0x11, funct3=011, and lw @ (DEPTH_WORDS*4) -> each returns err=1, rdata=0; a following lw @0x10 still returns 0x123455EF.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rdata are held stable and req_ready stays 0; raising rsp_ready completes the response and req_ready=1 on the next cycle. With WAIT_CYCLES=0, rsp_valid rises 1 cycle after accept.
- sw 0xCAFEF00D @0x20 with reset pulsed low during WAIT -> req_ready=1 and rsp_valid=0 immediately; a subsequent lw @0x20 returns the prior contents, not 0xCAFEF00D.
